// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pkg
//  Description : Shared types for the HI/LO multiply/divide sequencer.
//                - muldiv_op_t    : operation codes issued by decode
//                - muldiv_state_t : sequencer states
//                - MULDIV_STEPS   : iterations of the shift-add / restoring loop
//                - mag33()        : 33-bit magnitude of a signed or unsigned operand
//  Revision    : 1.0  initial release
// ============================================================================
package mips_cpu_pkg;

    localparam int MULDIV_STEPS = 32;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIX   = 2'd2,
        ST_WRITE = 2'd3
    } muldiv_state_t;

    // 33 bits so that |0x8000_0000| is representable without special-casing.
    function automatic logic [32:0] mag33(input logic [31:0] x, input logic is_signed);
        logic [32:0] ext;
        ext = {is_signed & x[31], x};
        return ext[32] ? (33'd0 - ext) : ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_muldiv_step
//  Description : One combinational iteration of the multiply/divide loop.
//                Multiply: acc = {hi, lo}, lo holds the remaining multiplier
//                bits; add operand to hi when lo[0] is set, then shift right.
//                Divide: acc = {remainder, quotient}; shift left, subtract
//                the divisor when it fits and shift in the quotient bit.
//  Ports       : acc_in  [63:0] accumulator before the step
//                operand [32:0] multiplicand or divisor magnitude
//                is_div         1 = divide step, 0 = multiply step
//                acc_out [63:0] accumulator after the step
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_muldiv_step (
    input  logic [63:0] acc_in,
    input  logic [32:0] operand,
    input  logic        is_div,
    output logic [63:0] acc_out
);

    logic [32:0] w_sum;
    logic [32:0] w_rem_shift;
    logic [31:0] w_diff;
    logic        w_ge;

    always_comb begin
        w_sum       = {1'b0, acc_in[63:32]} + operand;
        w_rem_shift = acc_in[63:31];
        w_ge        = (w_rem_shift >= operand);
        // When the divisor fits, the true difference is below 2^32, so the
        // modular low-word subtraction is exact.
        w_diff      = w_rem_shift[31:0] - operand[31:0];
        if (is_div) begin
            acc_out = w_ge ? {w_diff, acc_in[30:0], 1'b1}
                           : {w_rem_shift[31:0], acc_in[30:0], 1'b0};
        end else begin
            acc_out = acc_in[0] ? {w_sum, acc_in[31:1]}
                                : {1'b0, acc_in[63:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_muldiv_ctrl
//  Description : HI/LO sequencer. Runs MULT/MULTU (shift-add) and DIV/DIVU
//                (restoring) over magnitudes, fixes signs, then writes HI/LO.
//                MTHI/MTLO write straight through in IDLE. Stalls the pipe
//                while an operation is in flight and a new op or MFHI/MFLO
//                arrives.
//  Parameters  : MUL_FAST  1 = single-cycle '*' multiply, 0 = 32-step loop
//  Ports       : clk, reset (sync, active-high)
//                start, op[2:0], rs_data[31:0], rt_data[31:0]  - request
//                read_req                                       - MFHI/MFLO in EX
//                busy, stall                                    - status
//                hi_write_enable, lo_write_enable,
//                write_data_hi[31:0], write_data_lo[31:0]       - HI/LO write port
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_muldiv_ctrl
    import mips_cpu_pkg::*;
#(
    parameter int MUL_FAST = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        read_req,
    output logic        busy,
    output logic        stall,
    output logic        hi_write_enable,
    output logic        lo_write_enable,
    output logic [31:0] write_data_hi,
    output logic [31:0] write_data_lo
);

    localparam logic [4:0] c_LAST_STEP = 5'(MULDIV_STEPS - 1);

    muldiv_state_t r_state;
    logic [4:0]    r_count;
    logic [63:0]   r_acc;
    logic [32:0]   r_operand;
    logic          r_is_div;
    logic          r_div0;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [31:0]   r_data_hi;
    logic [31:0]   r_data_lo;

    logic          w_idle;
    logic          w_is_div_op;
    logic          w_signed_op;
    logic          w_accept;
    logic          w_div0;
    logic          w_mthi;
    logic          w_mtlo;
    logic [32:0]   w_mag_a;
    logic [32:0]   w_mag_b;
    logic [63:0]   w_step_acc;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    assign w_signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign w_accept    = w_idle & start &
                         ((op == MD_MULT) || (op == MD_MULTU) || w_is_div_op);
    assign w_div0      = w_is_div_op && (rt_data == 32'd0);
    assign w_mthi      = w_idle & start & (op == MD_MTHI);
    assign w_mtlo      = w_idle & start & (op == MD_MTLO);
    assign w_mag_a     = mag33(rs_data, w_signed_op);
    assign w_mag_b     = mag33(rt_data, w_signed_op);

    assign busy            = !w_idle;
    assign stall           = busy & (start | read_req);
    assign hi_write_enable = (r_state == ST_WRITE) | w_mthi;
    assign lo_write_enable = (r_state == ST_WRITE) | w_mtlo;
    assign write_data_hi   = w_mthi ? rs_data : r_data_hi;
    assign write_data_lo   = w_mtlo ? rs_data : r_data_lo;

    mips_cpu_muldiv_step u_step (
        .acc_in  (r_acc),
        .operand (r_operand),
        .is_div  (r_is_div),
        .acc_out (w_step_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= 5'd0;
            r_acc     <= 64'd0;
            r_operand <= 33'd0;
            r_is_div  <= 1'b0;
            r_div0    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_data_hi <= 32'd0;
            r_data_lo <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mthi) r_data_hi <= rs_data;
                    if (w_mtlo) r_data_lo <= rs_data;
                    if (w_accept) begin
                        r_count  <= 5'd0;
                        r_is_div <= w_is_div_op;
                        r_div0   <= w_div0;
                        r_neg_q  <= w_signed_op & (rs_data[31] ^ rt_data[31]);
                        r_neg_r  <= w_signed_op & rs_data[31];
                        // Loop operand is the multiplicand or divisor; the
                        // accumulator starts with multiplier or dividend.
                        r_operand <= w_is_div_op ? w_mag_b : w_mag_a;
                        if (w_div0) begin
                            // Divide by zero bypasses CALC; FIX passes the
                            // preloaded result through unchanged.
                            r_acc   <= {rs_data, 32'hFFFF_FFFF};
                            r_state <= ST_FIX;
                        end else begin
                            r_acc   <= {32'd0, w_is_div_op ? w_mag_a[31:0] : w_mag_b[31:0]};
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (!r_is_div && (MUL_FAST != 0)) begin
                        r_acc   <= {32'd0, r_acc[31:0]} * {32'd0, r_operand[31:0]};
                        r_state <= ST_FIX;
                    end else begin
                        r_acc   <= w_step_acc;
                        r_count <= r_count + 5'd1;
                        if (r_count == c_LAST_STEP) r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_div0) begin
                        r_data_hi <= r_acc[63:32];
                        r_data_lo <= r_acc[31:0];
                    end else if (r_is_div) begin
                        r_data_lo <= r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
                        r_data_hi <= r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
                    end else begin
                        {r_data_hi, r_data_lo} <= r_neg_q ? (64'd0 - r_acc) : r_acc;
                    end
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_muldiv_ctrl
//  Description : Self-checking bench for mips_cpu_muldiv_ctrl. Two instances
//                (MUL_FAST = 0 and 1) share the stimulus. Directed vector
//                table, hand-written stall/reset/MTHI sequences and random
//                operations checked against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cpu_muldiv_ctrl;
    import mips_cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        read_req;

    logic        s_busy, s_stall, s_hwe, s_lwe;
    logic [31:0] s_dhi, s_dlo;
    logic        f_busy, f_stall, f_hwe, f_lwe;
    logic [31:0] f_dhi, f_dlo;

    int n_checks;
    int n_errors;

    mips_cpu_muldiv_ctrl #(.MUL_FAST(0)) u_dut_slow (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .read_req(read_req),
        .busy(s_busy), .stall(s_stall),
        .hi_write_enable(s_hwe), .lo_write_enable(s_lwe),
        .write_data_hi(s_dhi), .write_data_lo(s_dlo)
    );

    mips_cpu_muldiv_ctrl #(.MUL_FAST(1)) u_dut_fast (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .read_req(read_req),
        .busy(f_busy), .stall(f_stall),
        .hi_write_enable(f_hwe), .lo_write_enable(f_lwe),
        .write_data_hi(f_dhi), .write_data_lo(f_dlo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        if ((o == MD_DIV || o == MD_DIVU) && b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (o == MD_MULT) begin
            res = sa * sb;
        end else if (o == MD_MULTU) begin
            res = ua * ub;
        end else if (o == MD_DIV) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else if (o == MD_DIVU) begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    // Cycle (counted from the accept cycle) in which HI/LO get written.
    function automatic int ref_latency(input logic fast, input logic [2:0] o, input logic [31:0] b);
        if ((o == MD_DIV || o == MD_DIVU) && b == 32'd0) return 2;
        if (fast && (o == MD_MULT || o == MD_MULTU)) return 3;
        return 34;
    endfunction

    // Issue one op in cycle 0, observe 41 cycles on the chosen instance.
    task automatic run_op(input logic fast, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int wcyc, output int nwr, output int busy_bad);
        logic        bsy, hwe, lwe;
        logic [31:0] dhi, dlo;
        hi = 32'd0; lo = 32'd0; wcyc = -1; nwr = 0; busy_bad = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            bsy = fast ? f_busy : s_busy;
            hwe = fast ? f_hwe  : s_hwe;
            lwe = fast ? f_lwe  : s_lwe;
            dhi = fast ? f_dhi  : s_dhi;
            dlo = fast ? f_dlo  : s_dlo;
            if (bsy !== (c >= 1 && c <= lat)) busy_bad++;
            if (hwe || lwe) begin
                nwr++;
                wcyc = c;
                hi = dhi;
                lo = dlo;
                if (!(hwe && lwe)) busy_bad++;
            end
            @(posedge clk); #1;
            start = 1'b0; op = MD_NOP;
        end
    endtask

    task automatic do_case(input string name, input logic fast, input logic [2:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_cyc);
        logic [31:0] hi, lo;
        int          wcyc, nwr, busy_bad;
        run_op(fast, o, a, b, exp_cyc, hi, lo, wcyc, nwr, busy_bad);
        check({name, " hi"},      {32'd0, hi}, {32'd0, exp_hi});
        check({name, " lo"},      {32'd0, lo}, {32'd0, exp_lo});
        check({name, " wcycle"},  64'(wcyc),   64'(exp_cyc));
        check({name, " nwrites"}, 64'(nwr),    64'd1);
        check({name, " busy"},    64'(busy_bad), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic        fast;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1; start = 1'b0; op = MD_NOP;
        rs_data = 32'd0; rt_data = 32'd0; read_req = 1'b0;

        vecs[0] = '{"multu_max",   1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        vecs[1] = '{"mult_m3x7",   1'b0, MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
        vecs[2] = '{"mult_m3x7_f", 1'b1, MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 3};
        vecs[3] = '{"multu_max_f", 1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
        vecs[4] = '{"div_m7_2",    1'b0, MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[5] = '{"divu_100_7",  1'b0, MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34};
        vecs[6] = '{"divu_5_0",    1'b0, MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 2};
        vecs[7] = '{"div_min_m1",  1'b0, MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst slow outs", {58'd0, s_busy, s_stall, s_hwe, s_lwe, |s_dhi, |s_dlo}, 64'd0);
        check("rst fast outs", {58'd0, f_busy, f_stall, f_hwe, f_lwe, |f_dhi, |f_dlo}, 64'd0);

        // Directed table
        for (int i = 0; i < 8; i++)
            do_case(vecs[i].name, vecs[i].fast, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].cyc);

        // MTHI / MTLO write straight through while idle
        @(posedge clk); #1;
        start = 1'b1; op = MD_MTHI; rs_data = 32'h1234_5678;
        @(negedge clk);
        check("mthi we",   {62'd0, s_hwe, s_lwe}, 64'h2);
        check("mthi data", {32'd0, s_dhi}, 64'h1234_5678);
        check("mthi busy", {63'd0, s_busy}, 64'd0);
        @(posedge clk); #1;
        op = MD_MTLO; rs_data = 32'hCAFE_F00D;
        @(negedge clk);
        check("mtlo we",   {62'd0, s_hwe, s_lwe}, 64'h1);
        check("mtlo data", {32'd0, s_dlo}, 64'hCAFE_F00D);
        @(posedge clk); #1;
        start = 1'b0; op = MD_NOP;
        @(negedge clk);
        check("mt hold", {s_dhi, s_dlo}, 64'h1234_5678_CAFE_F00D);
        check("mt we idle", {62'd0, s_hwe, s_lwe}, 64'd0);

        // Stall: DIV in cycle 0, held DIVU from cycle 5, read_req in 10..36
        begin
            logic [63:0] r1, r2;
            int          nwr;
            int          wc[2];
            logic [63:0] wd[2];
            logic        eb, es, er;
            r1 = ref_result(MD_DIV, 32'd1000, 32'hFFFF_FFFD);
            r2 = ref_result(MD_DIVU, 32'd100, 32'd7);
            nwr = 0; wc[0] = -1; wc[1] = -1; wd[0] = 64'd0; wd[1] = 64'd0;
            @(posedge clk); #1;
            start = 1'b1; op = MD_DIV; rs_data = 32'd1000; rt_data = 32'hFFFF_FFFD;
            for (int c = 0; c <= 75; c++) begin
                @(negedge clk);
                eb = (c >= 1 && c <= 34) || (c >= 36 && c <= 69);
                es = (c == 0) || (c >= 5 && c <= 35);
                er = (c >= 10 && c <= 36);
                if (c == 5 || c == 10 || c == 34 || c == 35 || c == 36 || c == 70)
                    check($sformatf("stall c%0d", c), {63'd0, s_stall}, {63'd0, eb & (es | er)});
                else if (s_stall !== (eb & (es | er)))
                    check($sformatf("stall c%0d", c), {63'd0, s_stall}, {63'd0, eb & (es | er)});
                if (s_hwe && s_lwe) begin
                    if (nwr < 2) begin
                        wc[nwr] = c;
                        wd[nwr] = {s_dhi, s_dlo};
                    end
                    nwr++;
                end
                @(posedge clk); #1;
                start    = ((c + 1) >= 5 && (c + 1) <= 35);
                op       = start ? MD_DIVU : MD_NOP;
                rs_data  = start ? 32'd100 : 32'd0;
                rt_data  = start ? 32'd7 : 32'd0;
                read_req = ((c + 1) >= 10 && (c + 1) <= 36);
            end
            start = 1'b0; read_req = 1'b0;
            check("stall nwrites", 64'(nwr), 64'd2);
            check("stall w1 cyc", 64'(wc[0]), 64'd34);
            check("stall w1 data", wd[0], r1);
            check("stall w2 cyc", 64'(wc[1]), 64'd69);
            check("stall w2 data", wd[1], r2);
        end

        // Reset in cycle 20 of a MULT abandons it
        begin
            int bad;
            @(posedge clk); #1;
            start = 1'b1; op = MD_MULT; rs_data = 32'd123; rt_data = 32'd456;
            @(posedge clk); #1;
            start = 1'b0; op = MD_NOP;
            repeat (19) @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            check("pre-reset busy", {63'd0, s_busy}, 64'd1);
            @(posedge clk); #1;
            reset = 1'b0;
            bad = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (s_busy || s_stall || s_hwe || s_lwe || s_dhi != 0 || s_dlo != 0) bad++;
            end
            check("post-reset quiet", 64'(bad), 64'd0);
            do_case("divu_after_rst", 1'b0, MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            logic        fast;
            logic [63:0] r;
            case ($urandom_range(3, 0))
                0: o = MD_MULT;
                1: o = MD_MULTU;
                2: o = MD_DIV;
                default: o = MD_DIVU;
            endcase
            fast = 1'($urandom_range(1, 0));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(15, 1);
                4: a = 32'd0;
                default: ;
            endcase
            r = ref_result(o, a, b);
            do_case($sformatf("rnd%0d op%0d", i, o), fast, o, a, b, r[63:32], r[31:0],
                    ref_latency(fast, o, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
